// File: rtl/alu_seq_divider.sv
// Iterative restoring divider (RV32M DIV/DIVU/REM/REMU) that issues one SUB per cycle to an external N+1-bit ALU.
// Optional macro DIVIDER_DBZ_BYPASS_EN: a zero divisor skips the ITER phase and completes in three cycles.
module alu_seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [2:0]   alu_opc,
    output logic [N:0]   alu_a,
    output logic [N:0]   alu_b,
    input  logic [N:0]   alu_w,
    input  logic         alu_neg
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

    state_t             state;
    logic [N-1:0]       a_l;
    logic [N-1:0]       b_l;
    logic               sgn_l;
    logic [N-1:0]       r_q;
    logic [N-1:0]       q_q;
    logic [N-1:0]       d_q;
    logic [CNT_W-1:0]   count;
    logic               sign_q;
    logic               sign_r;
    logic [N:0]         rs;
    logic               alu_w_msb_unused;

    // A successful subtract leaves a remainder below the divisor, so its MSB is always zero.
    assign alu_w_msb_unused = alu_w[N];

    function automatic logic [N-1:0] cond_neg(input logic en, input logic [N-1:0] v);
        logic signed [N-1:0] sv;
        sv = v;
        return en ? N'(-sv) : v;
    endfunction

    function automatic logic [N-1:0] magnitude(input logic is_signed, input logic [N-1:0] v);
        return cond_neg(is_signed && v[N-1], v);
    endfunction

    always_comb begin
        rs      = {r_q, q_q[N-1]};
        alu_opc = 3'b000;
        alu_a   = '0;
        alu_b   = '0;
        if (state == S_ITER) begin
            alu_opc = 3'b001;
            alu_a   = rs;
            alu_b   = {1'b0, d_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_l         <= '0;
            b_l         <= '0;
            sgn_l       <= 1'b0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_l   <= dividend;
                        b_l   <= divisor;
                        sgn_l <= signed_op;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    d_q    <= magnitude(sgn_l, b_l);
                    q_q    <= magnitude(sgn_l, a_l);
                    sign_q <= sgn_l & (a_l[N-1] ^ b_l[N-1]);
                    sign_r <= sgn_l & a_l[N-1];
                    r_q    <= '0;
                    count  <= '0;
`ifdef DIVIDER_DBZ_BYPASS_EN
                    state  <= (b_l == '0) ? S_FIX : S_ITER;
`else
                    state  <= S_ITER;
`endif
                end
                S_ITER: begin
                    // Restore on a negative trial subtract, otherwise keep the ALU difference.
                    if (!alu_neg) begin
                        r_q <= alu_w[N-1:0];
                        q_q <= {q_q[N-2:0], 1'b1};
                    end else begin
                        r_q <= rs[N-1:0];
                        q_q <= {q_q[N-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(N - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (d_q == '0) begin
                        quotient    <= '1;
                        remainder   <= a_l;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= cond_neg(sign_q, q_q);
                        remainder   <= cond_neg(sign_r, r_q);
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: directed RV32M corner cases plus randomized operands against a reference model.
// Honours DIVIDER_DBZ_BYPASS_EN for the expected divide-by-zero latency.
module tb_alu_seq_divider;

    localparam int N   = 32;
    localparam int LAT = N + 3;
`ifdef DIVIDER_DBZ_BYPASS_EN
    localparam int LAT_DBZ = 3;
`else
    localparam int LAT_DBZ = N + 3;
`endif

    localparam logic [N-1:0] TA [6] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h12345678, 32'h80000000, 32'h80000000};
    localparam logic [N-1:0] TB [6] = '{32'd7,   32'd1,        32'd2,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    localparam logic         TS [6] = '{1'b0,    1'b0,         1'b1,         1'b1,         1'b1,         1'b0};
    localparam logic [N-1:0] EQ [6] = '{32'd14,  32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    localparam logic [N-1:0] ER [6] = '{32'd2,   32'd0,        32'hFFFFFFFF, 32'h12345678, 32'd0,        32'h80000000};
    localparam logic         EZ [6] = '{1'b0,    1'b0,         1'b0,         1'b1,         1'b0,         1'b0};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic [2:0]   alu_opc;
    logic [N:0]   alu_a;
    logic [N:0]   alu_b;
    logic [N:0]   alu_w;
    logic         alu_neg;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Private N+1-bit ALU serving the divider.
    assign alu_w   = (alu_opc == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_neg = alu_w[N];

    alu_seq_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .alu_w(alu_w), .alu_neg(alu_neg)
    );

    // RISC-V division semantics from plain arithmetic.
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                    output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        sa = a;
        sb = b;
        z  = (b == '0);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = a;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Starts an op in the current cycle and returns in the done cycle (or after a bounded wait).
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, output int lat);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
        n_cmp++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        n_cmp++; if (alu_opc !== 3'b000) begin n_fail++; $display("FAIL reset_alu_opc: got %b expected 000", alu_opc); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_timing();
        dividend  = 32'd100;
        divisor   = 32'd7;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            n_cmp++; if (busy !== (k <= LAT - 1)) begin n_fail++; $display("FAIL timing_busy c%0d: got %b expected %b", k, busy, (k <= LAT - 1)); end
            n_cmp++; if (done !== (k == LAT)) begin n_fail++; $display("FAIL timing_done c%0d: got %b expected %b", k, done, (k == LAT)); end
            n_cmp++;
            if (alu_opc !== ((k >= 2 && k <= N + 1) ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL timing_alu_opc c%0d: got %b", k, alu_opc);
            end
            if (k <= LAT) begin
                @(posedge clk); #1;
            end
        end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL timing_q: got %h expected 0000000e", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL timing_r: got %h expected 00000002", remainder); end
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(TA[i], TB[i], TS[i], lat);
            n_cmp++; if (quotient !== EQ[i]) begin n_fail++; $display("FAIL dir%0d_q: got %h expected %h", i, quotient, EQ[i]); end
            n_cmp++; if (remainder !== ER[i]) begin n_fail++; $display("FAIL dir%0d_r: got %h expected %h", i, remainder, ER[i]); end
            n_cmp++; if (div_by_zero !== EZ[i]) begin n_fail++; $display("FAIL dir%0d_dbz: got %b expected %b", i, div_by_zero, EZ[i]); end
            n_cmp++;
            if (lat != (EZ[i] ? LAT_DBZ : LAT)) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, (EZ[i] ? LAT_DBZ : LAT));
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        int lat;
        dividend  = 32'hDEADBEEF;
        divisor   = 32'h1234;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_cmp++; if (quotient !== '0) begin n_fail++; $display("FAIL abort_q: got %h expected 0", quotient); end
        n_cmp++; if (remainder !== '0) begin n_fail++; $display("FAIL abort_r: got %h expected 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dbz: got %b expected 0", div_by_zero); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
        run_op(32'd9, 32'd3, 1'b0, lat);
        n_cmp++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL abort_next_q: got %h expected 3", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL abort_next_r: got %h expected 0", remainder); end
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic z;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                start     = 1'b1;
                dividend  = 32'd77;
                divisor   = 32'd3;
                signed_op = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (quotient !== 32'd100) begin n_fail++; $display("FAIL b2b_first_q: got %h expected 00000064", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_first_r: got %h expected 0", remainder); end
        run_op(32'hFFFFFF9C, 32'd7, 1'b1, lat);
        ref_div(32'hFFFFFF9C, 32'd7, 1'b1, q, r, z);
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (quotient !== q) begin n_fail++; $display("FAIL b2b_second_q: got %h expected %h", quotient, q); end
        n_cmp++; if (remainder !== r) begin n_fail++; $display("FAIL b2b_second_r: got %h expected %h", remainder, r); end
    endtask

    task automatic test_random();
        int lat;
        int sel;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic s;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic z;
        for (int i = 0; i < 300; i++) begin
            a   = $urandom;
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                4: begin a = $urandom_range(0, 100); b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(a, b, s, q, r, z);
            run_op(a, b, s, lat);
            n_cmp++; if (quotient !== q) begin n_fail++; $display("FAIL rnd%0d_q a=%h b=%h s=%b: got %h expected %h", i, a, b, s, quotient, q); end
            n_cmp++; if (remainder !== r) begin n_fail++; $display("FAIL rnd%0d_r a=%h b=%h s=%b: got %h expected %h", i, a, b, s, remainder, r); end
            n_cmp++; if (div_by_zero !== z) begin n_fail++; $display("FAIL rnd%0d_dbz: got %b expected %b", i, div_by_zero, z); end
            n_cmp++;
            if (lat != (z ? LAT_DBZ : LAT)) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, (z ? LAT_DBZ : LAT));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_timing();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
